lcd_digit_writer: RTL and testbench
===================================

# lcd_digit_writer

Parametrised LCD line writer for the digital clock: latches a packed vector of BCD/hex digits, converts each to its LCD character code, optionally inserts ':' separators, and streams the result to an HD44780-style character LCD (8-bit bus, write-only) starting at a chosen DDRAM address. It replaces the purely combinational single-digit mapping with a self-timed, multi-digit sequencer. It sits between the time-keeping counters and the LCD pins.

## Interface
- NUM_DIGITS, 6, digits per update (1..16); digit 0 is leftmost, in bits [4*NUM_DIGITS-1 -: 4]
- SEP_EN, 1, insert ':' (0x3A) after every second digit, never after the last
- HEX_MODE, 0, 1: codes 0xA-0xF map to 'A'-'F' (0x41-0x46); 0: they map to space (0x20)
- E_HIGH, 12, cycles lcd_e is held high per transfer (>=1)
- GAP, 2000, idle cycles after each transfer for LCD execution time (>=0)

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request an update; sampled only in IDLE
- digits  in  4*NUM_DIGITS  digit values, latched on accepted start
- addr  in  7  DDRAM start address, latched on accepted start
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  constant 0
- lcd_e  out  1  LCD enable strobe
- lcd_data  out  8  LCD data bus
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle pulse at completion

## Operation
- CHARS = NUM_DIGITS + (SEP_EN ? (NUM_DIGITS-1)/2 : 0).
- FSM states: IDLE, ADDR, CHAR, FINISH. Each transfer in ADDR/CHAR runs phases SETUP, PULSE, HOLD, WAIT.
- IDLE: start=1 at an edge latches digits and addr, goes to ADDR. start in any other state is ignored (not queued).
- ADDR: one command transfer, lcd_rs=0, lcd_data = 0x80 | addr.
- CHAR: CHARS data transfers, lcd_rs=1, left to right. Character index i counts 0..CHARS-1; separators occupy positions 2, 5, 8, ... when SEP_EN.
- Mapping: 0-9 -> 0x30+d; 0xA-0xF per HEX_MODE.
- FINISH: done=1 for one cycle, busy=0, return to IDLE. start in the FINISH cycle is ignored.
- Digit inputs changing mid-update have no effect (latched copy is used).

## Timing
- Transfer length T = 2 + E_HIGH + GAP cycles: SETUP 1 cycle (data/rs valid, e=0), PULSE E_HIGH cycles (e=1), HOLD 1 cycle (e=0, data/rs unchanged), WAIT GAP cycles (e=0, data unchanged).
- start accepted at edge k: busy=1 and ADDR SETUP in cycle k+1; done=1, busy=0 in cycle k+1+(1+CHARS)*T; next start accepted at the following edge.
- lcd_data and lcd_rs change only at SETUP entry.
- Reset (any time, including mid-transfer): immediately lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, busy=0, done=0, FSM IDLE, counters 0. Release is synchronised by the existing reset network; no partial transfer resumes.
- Phase counter width: clog2(max(E_HIGH, GAP)+1); character index width: clog2(CHARS+1).

## Structure
- Shared package lcd_pkg: ASCII constants (ASCII_0=0x30, ASCII_A=0x41, ASCII_SPACE=0x20, ASCII_COLON=0x3A), LCD_CMD_SET_DDRAM=0x80, FSM state and phase enum typedefs.
- Sub-module lcd_char_map: combinational 4-bit code + HEX_MODE -> 8-bit character; instantiated once, fed by a mux on the latched digit vector.

## Test plan
- NUM_DIGITS=6, SEP_EN=1, E_HIGH=2, GAP=3, digits=0x123456, addr=0x40, start at edge k -> bus sequence (rs,data): (0,0xC0),(1,'1'),(1,'2'),(1,':'),(1,'3'),(1,'4'),(1,':'),(1,'5'),(1,'6'); each e pulse exactly 2 cycles; done at k+64.
- HEX_MODE=0, digits include 0xA and 0xF -> both written as 0x20; HEX_MODE=1 -> 0x41 and 0x46.
- SEP_EN=0, NUM_DIGITS=4, digits=0x0909 -> "0909", 4 data transfers, done at k+1+5*T.
- start pulsed while busy and in FINISH cycle -> ignored; exactly one update, single done pulse.
- rst_n asserted during PULSE of the third character -> lcd_e drops asynchronously, all outputs 0; after release, new start produces full correct sequence from ADDR.
- Digits changed one cycle after acceptance -> output uses originally latched value.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants and enum types for the LCD line writer.
package lcd_pkg;

  localparam logic [7:0] ASCII_0           = 8'h30;
  localparam logic [7:0] ASCII_A           = 8'h41;
  localparam logic [7:0] ASCII_SPACE       = 8'h20;
  localparam logic [7:0] ASCII_COLON       = 8'h3A;
  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CHAR,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_PULSE,
    PH_HOLD,
    PH_WAIT
  } phase_t;

endpackage

// File: rtl/lcd_char_map.sv
// Maps one 4-bit digit code to its LCD character code.
module lcd_char_map
  import lcd_pkg::*;
#(
  parameter bit HEX_MODE = 1'b0
) (
  input  logic [3:0] code,
  output logic [7:0] ch
);

  // decimal digits always map to '0'..'9'; 0xA..0xF depend on HEX_MODE
  always_comb begin
    if (code < 4'd10)
      ch = ASCII_0 + {4'b0000, code};
    else if (HEX_MODE)
      ch = ASCII_A + {4'b0000, code - 4'd10};
    else
      ch = ASCII_SPACE;
  end

endmodule

// File: rtl/lcd_digit_writer.sv
// Multi-digit LCD line writer: latches a digit vector and streams the set-DDRAM
// command followed by the converted characters to an HD44780-style bus.
//
//   state  | meaning
//   IDLE   | waiting for start
//   ADDR   | set-DDRAM-address command transfer
//   CHAR   | character data transfers, left to right
//   FINISH | one-cycle done pulse, then back to IDLE
module lcd_digit_writer
  import lcd_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter bit SEP_EN     = 1'b1,
  parameter bit HEX_MODE   = 1'b0,
  parameter int E_HIGH     = 12,
  parameter int GAP        = 2000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [6:0]              addr,
  output logic                    lcd_rs,
  output logic                    lcd_rw,
  output logic                    lcd_e,
  output logic [7:0]              lcd_data,
  output logic                    busy,
  output logic                    done
);

  localparam int DW     = 4 * NUM_DIGITS;
  localparam int CHARS  = NUM_DIGITS + (SEP_EN ? (NUM_DIGITS - 1) / 2 : 0);
  localparam int PMAX   = (E_HIGH > GAP) ? E_HIGH : GAP;
  localparam int PW     = $clog2(PMAX + 1);
  localparam int IDX_W  = $clog2(CHARS + 1);
  localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

  localparam logic [PW-1:0]    E_LOAD   = PW'(E_HIGH - 1);
  localparam logic [PW-1:0]    GAP_LOAD = PW'(GAP_M1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHARS - 1);

  state_t            state;
  phase_t            phase;
  logic [PW-1:0]     cnt;
  logic [IDX_W-1:0]  idx;
  logic [DW-1:0]     digits_q;

  logic [IDX_W-1:0]  nidx;
  logic [7:0]        n8;
  logic [7:0]        grp;
  logic [7:0]        rem;
  logic [7:0]        dsel;
  logic [3:0]        code;
  logic              is_sep;
  logic [7:0]        mapped;
  logic [7:0]        next_char;
  logic              xfer_last;

  assign lcd_rw = 1'b0;

  // Pick the digit for the next character slot; every third slot is a separator
  // when SEP_EN, so the digit index is the slot index minus the separators before it.
  always_comb begin
    nidx   = (state == ST_ADDR) ? '0 : idx + IDX_W'(1);
    n8     = 8'(nidx);
    grp    = n8 / 8'd3;
    rem    = n8 - grp * 8'd3;
    dsel   = SEP_EN ? n8 - grp : n8;
    is_sep = SEP_EN && (rem == 8'd2);
    code   = '0;
    for (int j = 0; j < NUM_DIGITS; j++)
      if (dsel == 8'(j))
        code = digits_q[DW-1-4*j -: 4];
  end

  lcd_char_map #(.HEX_MODE(HEX_MODE)) u_char_map (
    .code (code),
    .ch   (mapped)
  );

  // Final character value and end-of-transfer detect
  always_comb begin
    next_char = is_sep ? ASCII_COLON : mapped;
    xfer_last = ((phase == PH_HOLD) && (GAP == 0)) ||
                ((phase == PH_WAIT) && (cnt == '0));
  end

  // Sequencer: state, transfer phase, timers and registered bus outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      phase    <= PH_SETUP;
      cnt      <= '0;
      idx      <= '0;
      digits_q <= '0;
      lcd_rs   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_data <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            digits_q <= digits;
            state    <= ST_ADDR;
            phase    <= PH_SETUP;
            lcd_rs   <= 1'b0;
            lcd_data <= LCD_CMD_SET_DDRAM | {1'b0, addr};
            busy     <= 1'b1;
          end
        end
        ST_ADDR, ST_CHAR: begin
          if (xfer_last) begin
            phase <= PH_SETUP;
            if (state == ST_CHAR && idx == LAST_IDX) begin
              state <= ST_FINISH;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= ST_CHAR;
              idx      <= nidx;
              lcd_rs   <= 1'b1;
              lcd_data <= next_char;
            end
          end else begin
            unique case (phase)
              PH_SETUP: begin
                phase <= PH_PULSE;
                cnt   <= E_LOAD;
                lcd_e <= 1'b1;
              end
              PH_PULSE: begin
                if (cnt == '0) begin
                  phase <= PH_HOLD;
                  lcd_e <= 1'b0;
                end else begin
                  cnt <= cnt - PW'(1);
                end
              end
              PH_HOLD: begin
                phase <= PH_WAIT;
                cnt   <= GAP_LOAD;
              end
              PH_WAIT: begin
                cnt <= cnt - PW'(1);
              end
              default: phase <= PH_SETUP;
            endcase
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
          idx   <= '0;
          cnt   <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_digit_writer.sv
// Randomised self-checking bench for lcd_digit_writer using three configurations.
module tb_lcd_digit_writer;

  localparam int ND [3] = '{6, 6, 4};
  localparam int SP [3] = '{1, 1, 0};
  localparam int HX [3] = '{0, 1, 1};
  localparam int EH [3] = '{2, 2, 1};
  localparam int GP [3] = '{3, 3, 0};

  logic        clk;
  logic        rst_n;
  logic        start_v  [3];
  logic [23:0] digits_v [3];
  logic [6:0]  addr_v   [3];
  logic        rs_v     [3];
  logic        rw_v     [3];
  logic        e_v      [3];
  logic [7:0]  data_v   [3];
  logic        busy_v   [3];
  logic        done_v   [3];

  int n_vec = 0;
  int n_bad = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  lcd_digit_writer #(.NUM_DIGITS(6), .SEP_EN(1'b1), .HEX_MODE(1'b0), .E_HIGH(2), .GAP(3)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .digits(digits_v[0]), .addr(addr_v[0]),
    .lcd_rs(rs_v[0]), .lcd_rw(rw_v[0]), .lcd_e(e_v[0]), .lcd_data(data_v[0]),
    .busy(busy_v[0]), .done(done_v[0]));

  lcd_digit_writer #(.NUM_DIGITS(6), .SEP_EN(1'b1), .HEX_MODE(1'b1), .E_HIGH(2), .GAP(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .digits(digits_v[1]), .addr(addr_v[1]),
    .lcd_rs(rs_v[1]), .lcd_rw(rw_v[1]), .lcd_e(e_v[1]), .lcd_data(data_v[1]),
    .busy(busy_v[1]), .done(done_v[1]));

  lcd_digit_writer #(.NUM_DIGITS(4), .SEP_EN(1'b0), .HEX_MODE(1'b1), .E_HIGH(1), .GAP(0)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .digits(digits_v[2][15:0]), .addr(addr_v[2]),
    .lcd_rs(rs_v[2]), .lcd_rw(rw_v[2]), .lcd_e(e_v[2]), .lcd_data(data_v[2]),
    .busy(busy_v[2]), .done(done_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected bus transfers: address command, then each digit's character with
  // a colon after every second digit unless it is the last one.
  task automatic build_expected(input int inst, input logic [23:0] dv, input logic [6:0] av);
    int nd;
    int d;
    logic [7:0] c;
    nd = ND[inst];
    exp_q.delete();
    exp_q.push_back({1'b0, 1'b1, av});
    for (int i = 0; i < nd; i++) begin
      d = int'((dv >> (4 * (nd - 1 - i))) & 24'hF);
      if (d < 10)           c = 8'(8'h30 + d);
      else if (HX[inst] != 0) c = 8'(8'h41 + d - 10);
      else                  c = 8'h20;
      exp_q.push_back({1'b1, c});
      if (SP[inst] != 0 && (i % 2) == 1 && i != nd - 1)
        exp_q.push_back({1'b1, 8'h3A});
    end
  endtask

  task automatic run_update(input int inst, input logic [23:0] dv, input logic [6:0] av,
                            input bit poke);
    int t_len;
    int exp_done;
    int done_cyc;
    int elen;
    logic pe;
    logic [8:0] prev_bus;
    logic [8:0] cur_bus;

    build_expected(inst, dv, av);
    t_len    = 2 + EH[inst] + GP[inst];
    exp_done = 1 + exp_q.size() * t_len;
    got_q.delete();
    done_cyc = -1;
    elen     = 0;
    pe       = 1'b0;
    prev_bus = '0;

    @(negedge clk);
    start_v[inst]  = 1'b1;
    digits_v[inst] = dv;
    addr_v[inst]   = av;
    @(posedge clk); #1;
    start_v[inst] = 1'b0;

    for (int cyc = 1; cyc <= exp_done + 8 && done_cyc < 0; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk); #1;
      end
      if (cyc == 1) chk("busy_first", 32'(busy_v[inst]), 32'd1);
      if (cyc == 2) digits_v[inst] = 24'($urandom);
      if (poke && cyc == 3) start_v[inst] = 1'b1;
      if (poke && cyc == 4) start_v[inst] = 1'b0;
      cur_bus = {rs_v[inst], data_v[inst]};
      if (e_v[inst] && !pe) begin
        got_q.push_back(cur_bus);
        chk("setup_valid", 32'(prev_bus), 32'(cur_bus));
      end
      if (e_v[inst]) elen++;
      if (!e_v[inst] && pe) begin
        chk("e_width", 32'(elen), 32'(EH[inst]));
        if (got_q.size() > 0) chk("bus_stable", 32'(cur_bus), 32'(got_q[got_q.size() - 1]));
        elen = 0;
      end
      if (done_v[inst]) begin
        done_cyc = cyc;
        chk("busy_at_done", 32'(busy_v[inst]), 32'd0);
      end
      pe       = e_v[inst];
      prev_bus = cur_bus;
    end

    chk("done_cycle", 32'(done_cyc), 32'(exp_done));
    chk("xfer_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("xfer%0d", i), 32'(got_q[i]), 32'(exp_q[i]));

    if (poke) start_v[inst] = 1'b1;
    @(posedge clk); #1;
    start_v[inst] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("idle_after", 32'({busy_v[inst], done_v[inst], e_v[inst]}), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int rises;
    logic pe;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_v[i]  = 1'b0;
      digits_v[i] = '0;
      addr_v[i]   = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_outs%0d", i),
          32'({rs_v[i], rw_v[i], e_v[i], busy_v[i], done_v[i], data_v[i]}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_update(0, 24'h123456, 7'h40, 1'b0);
    run_update(0, 24'hA0F3B1, 7'h00, 1'b0);
    run_update(1, 24'hA0F3B1, 7'h10, 1'b0);
    run_update(2, 24'h000909, 7'h00, 1'b0);
    run_update(0, 24'h112233, 7'h01, 1'b1);
    run_update(2, 24'h00FA3C, 7'h7F, 1'b1);

    // reset during the enable pulse of the third character
    @(negedge clk);
    start_v[0]  = 1'b1;
    digits_v[0] = 24'h987654;
    addr_v[0]   = 7'h05;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    rises = 0;
    pe    = 1'b0;
    for (int c = 0; c < 500 && rises < 4; c++) begin
      if (e_v[0] && !pe) rises++;
      pe = e_v[0];
      if (rises < 4) begin
        @(posedge clk); #1;
      end
    end
    chk("rst_in_pulse", 32'(e_v[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs",
        32'({rs_v[0], rw_v[0], e_v[0], busy_v[0], done_v[0], data_v[0]}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_outs",
        32'({rs_v[0], e_v[0], busy_v[0], done_v[0], data_v[0]}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_update(0, 24'h987654, 7'h05, 1'b0);

    for (int k = 0; k < 6; k++)
      for (int i = 0; i < 3; i++)
        run_update(i, 24'($urandom), 7'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
